// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage with an optional direct-mapped I-cache.
// Holds the PC and hands instruction words to IF/ID. On a miss it raises a held
// request to the memory controller's IF port and waits for a one-cycle
// completion pulse. Redirects come from EX (jump_i), stalls from pipeline control.
// Define ICACHE_EN to build the cache. Without it, every fetch takes the miss path.
//
// Ports:
//   clk, rst (async, active-high), rdy (global enable; all state holds while low)
//   stall_i            IF/ID cannot accept; presented word and pc hold
//   jump_i/jump_addr_i single-cycle redirect from EX
//   if_addr/if_request fetch address and level request to memory controller
//   mem_inst_i/mem_inst_valid_i  returned word and its completion pulse
//   pc_o/inst_o/valid_o          instruction to IF/ID (registered)
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IDX_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic [31:0] if_addr,
  output logic        if_request,
  input  logic [31:0] mem_inst_i,
  input  logic        mem_inst_valid_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {RUN, MISS, DISCARD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_inc_c;
  logic [31:0] pc_o_n, inst_o_n, if_addr_n;
  logic        valid_o_n, if_req_n;
  logic        hold_v, hold_v_n;
  logic [31:0] hold_inst, hold_inst_n;
  logic        fill_c;
  logic        hit_c;
  logic [31:0] hit_data_c;

`ifdef ICACHE_EN
  localparam int unsigned TAG_W = 32 - IDX_W - 2;
  localparam int unsigned LINES = 1 << IDX_W;

  logic [LINES-1:0] line_valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic [IDX_W-1:0] rd_idx_c, wr_idx_c;

  assign rd_idx_c   = pc[IDX_W+1:2];
  assign wr_idx_c   = if_addr[IDX_W+1:2];
  assign hit_c      = line_valid[rd_idx_c] && (tag_mem[rd_idx_c] == pc[31:IDX_W+2]);
  assign hit_data_c = data_mem[rd_idx_c];

  // Valid bits need reset; tag/data arrays do not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid <= '0;
    end else if (rdy && fill_c) begin
      line_valid[wr_idx_c] <= 1'b1;
    end
  end

  // Every returned word is filled, including discarded ones: the address is genuine.
  always_ff @(posedge clk) begin
    if (rdy && fill_c) begin
      tag_mem[wr_idx_c]  <= if_addr[31:IDX_W+2];
      data_mem[wr_idx_c] <= mem_inst_i;
    end
  end
`else
  assign hit_c      = 1'b0;
  assign hit_data_c = 32'h0;
`endif

  assign pc_inc_c = pc + 32'd4;

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pc_o_n      = pc_o;
    inst_o_n    = inst_o;
    valid_o_n   = valid_o;
    if_addr_n   = if_addr;
    if_req_n    = if_request;
    hold_v_n    = hold_v;
    hold_inst_n = hold_inst;
    fill_c      = 1'b0;
    case (state)
      RUN: begin
        if (jump_i) begin
          pc_n      = jump_addr_i;
          valid_o_n = 1'b0;
          hold_v_n  = 1'b0;
        end else if (!stall_i) begin
          if (hold_v) begin
            // Word completed under stall; present it now.
            valid_o_n = 1'b1;
            inst_o_n  = hold_inst;
            pc_o_n    = pc;
            pc_n      = pc_inc_c;
            hold_v_n  = 1'b0;
          end else if (hit_c) begin
            valid_o_n = 1'b1;
            inst_o_n  = hit_data_c;
            pc_o_n    = pc;
            pc_n      = pc_inc_c;
          end else begin
            valid_o_n = 1'b0;
            if_addr_n = pc;
            if_req_n  = 1'b1;
            state_n   = MISS;
          end
        end
      end
      MISS: begin
        if (mem_inst_valid_i) begin
          fill_c   = 1'b1;
          if_req_n = 1'b0;
          state_n  = RUN;
        end
        if (jump_i) begin
          // Redirect wins over a simultaneous response; the line is still filled.
          pc_n      = jump_addr_i;
          valid_o_n = 1'b0;
          hold_v_n  = 1'b0;
          if (!mem_inst_valid_i) state_n = DISCARD;
        end else if (mem_inst_valid_i) begin
          if (stall_i) begin
            hold_v_n    = 1'b1;
            hold_inst_n = mem_inst_i;
          end else begin
            valid_o_n = 1'b1;
            inst_o_n  = mem_inst_i;
            pc_o_n    = pc;
            pc_n      = pc_inc_c;
          end
        end
      end
      DISCARD: begin
        if (jump_i) pc_n = jump_addr_i;
        if (mem_inst_valid_i) begin
          fill_c   = 1'b1;
          if_req_n = 1'b0;
          state_n  = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // State and registered outputs; everything freezes while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      pc_o       <= 32'h0;
      inst_o     <= 32'h0;
      valid_o    <= 1'b0;
      if_addr    <= 32'h0;
      if_request <= 1'b0;
      hold_v     <= 1'b0;
      hold_inst  <= 32'h0;
    end else if (rdy) begin
      state      <= state_n;
      pc         <= pc_n;
      pc_o       <= pc_o_n;
      inst_o     <= inst_o_n;
      valid_o    <= valid_o_n;
      if_addr    <= if_addr_n;
      if_request <= if_req_n;
      hold_v     <= hold_v_n;
      hold_inst  <= hold_inst_n;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch. The bench plays the memory controller: it returns
// word(addr) = addr ^ 32'h93, so word(0) = 32'h0000_0093.
// The cache-specific expectations are selected with ICACHE_EN.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, stall_i, jump_i, mem_inst_valid_i;
  logic [31:0] jump_addr_i, mem_inst_i;
  logic [31:0] if_addr, pc_o, inst_o;
  logic        if_request, valid_o;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  if_fetch #(.RESET_PC(32'h0), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .if_addr(if_addr), .if_request(if_request),
    .mem_inst_i(mem_inst_i), .mem_inst_valid_i(mem_inst_valid_i),
    .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h0000_0093;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for a request, check it is held, return word(addr) after lat cycles.
  task automatic serve(input logic [31:0] addr, input int lat);
    int n = 0;
    while (!if_request && n < 50) begin
      tick();
      n++;
    end
    chk("req_up", 32'(if_request), 32'd1);
    chk("req_addr", if_addr, addr);
    repeat (lat) tick();
    chk("req_held", 32'(if_request), 32'd1);
    chk("addr_held", if_addr, addr);
    mem_inst_i       = word(addr);
    mem_inst_valid_i = 1'b1;
    tick();
    mem_inst_valid_i = 1'b0;
    chk("miss_valid", 32'(valid_o), 32'd1);
    chk("miss_inst", inst_o, word(addr));
    chk("miss_pc", pc_o, addr);
    chk("req_drop", 32'(if_request), 32'd0);
  endtask

  // Expect a cache hit to be presented on the next cycle with no request.
  task automatic hit(input logic [31:0] addr);
    tick();
    chk("hit_valid", 32'(valid_o), 32'd1);
    chk("hit_inst", inst_o, word(addr));
    chk("hit_pc", pc_o, addr);
    chk("hit_noreq", 32'(if_request), 32'd0);
  endtask

  task automatic jump_to(input logic [31:0] addr);
    jump_i      = 1'b1;
    jump_addr_i = addr;
    tick();
    jump_i = 1'b0;
    chk("jump_valid", 32'(valid_o), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; jump_i = 1'b0;
    jump_addr_i = 32'h0; mem_inst_i = 32'h0; mem_inst_valid_i = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(if_request), 32'd0);
    chk("rst_addr", if_addr, 32'h0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    rst = 1'b0;

    // First fetch from reset PC, then the next sequential address.
    serve(32'h0, 4);
    chk("first_inst", inst_o, 32'h0000_0093);
    serve(32'h4, 4);

    // Redirect two cycles into the miss at 0x8: the request is not aborted.
    n = 0;
    while (!if_request && n < 50) begin tick(); n++; end
    chk("m8_addr", if_addr, 32'h8);
    tick();
    tick();
    jump_to(32'h100);
    chk("disc_addr", if_addr, 32'h8);
    chk("disc_req", 32'(if_request), 32'd1);
    tick();
    mem_inst_i = word(32'h8); mem_inst_valid_i = 1'b1;
    tick();
    mem_inst_valid_i = 1'b0;
    chk("disc_novalid", 32'(valid_o), 32'd0);
    chk("disc_reqdrop", 32'(if_request), 32'd0);
    serve(32'h100, 4);

    // 0x100 aliases line 0, so 0x0 misses again.
    jump_to(32'h0);
    serve(32'h0, 5);
`ifdef ICACHE_EN
    hit(32'h4);
    hit(32'h8);
`else
    serve(32'h4, 4);
    serve(32'h8, 4);
`endif
    serve(32'hC, 4);

    // Second pass over the loop 0x0..0xC.
    jump_to(32'h0);
    chk("loop_noreq", 32'(if_request), 32'd0);
`ifdef ICACHE_EN
    hit(32'h0);
    hit(32'h4);
    hit(32'h8);
    hit(32'hC);
`else
    serve(32'h0, 4);
    serve(32'h4, 4);
    serve(32'h8, 4);
    serve(32'hC, 4);
`endif

    // Miss at 0x10 completes under stall and is presented once the stall drops.
    n = 0;
    while (!if_request && n < 50) begin tick(); n++; end
    chk("m10_addr", if_addr, 32'h10);
    stall_i = 1'b1;
    repeat (3) tick();
    mem_inst_i = word(32'h10); mem_inst_valid_i = 1'b1;
    tick();
    mem_inst_valid_i = 1'b0;
    chk("stall_valid", 32'(valid_o), 32'd0);
    chk("stall_pc_o", pc_o, 32'hC);
    chk("stall_reqdrop", 32'(if_request), 32'd0);
    tick();
    tick();
    chk("stall_noreq", 32'(if_request), 32'd0);
    stall_i = 1'b0;
    tick();
    chk("unstall_valid", 32'(valid_o), 32'd1);
    chk("unstall_inst", inst_o, word(32'h10));
    chk("unstall_pc_o", pc_o, 32'h10);
    chk("unstall_noreq", 32'(if_request), 32'd0);
    tick();
    chk("next_req", 32'(if_request), 32'd1);
    chk("next_addr", if_addr, 32'h14);

    // Reset in the middle of the 0x14 miss; stray pulses are ignored.
    rst = 1'b1;
    #1;
    chk("mrst_req", 32'(if_request), 32'd0);
    chk("mrst_valid", 32'(valid_o), 32'd0);
    chk("mrst_pc_o", pc_o, 32'h0);
    mem_inst_i = word(32'h14); mem_inst_valid_i = 1'b1;
    tick();
    mem_inst_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    mem_inst_valid_i = 1'b1;
    tick();
    mem_inst_valid_i = 1'b0;
    chk("stray_valid", 32'(valid_o), 32'd0);
    chk("stray_req", 32'(if_request), 32'd1);
    chk("stray_addr", if_addr, 32'h0);
    serve(32'h0, 4);

    // rdy low freezes everything, including the next lookup.
    rdy = 1'b0;
    tick();
    tick();
    chk("rdy_valid", 32'(valid_o), 32'd1);
    chk("rdy_pc_o", pc_o, 32'h0);
    chk("rdy_noreq", 32'(if_request), 32'd0);
    rdy = 1'b1;
    tick();
    chk("rdy_req", 32'(if_request), 32'd1);
    chk("rdy_addr", if_addr, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage with an optional direct-mapped instruction cache. Holds the PC, serves instruction words to IF/ID, and on a miss issues a held fetch request to the memory controller's IF port (byte-serial, 4-beat fetch, one-cycle completion pulse). It accepts redirects from EX and stalls from the pipeline control block.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- IDX_W, 6, log2 of cache lines (one 32-bit word per line)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- rdy  in  1  global enable; all state holds while low
- stall_i  in  1  IF/ID cannot accept; current output held
- jump_i  in  1  redirect request from EX, single-cycle pulse
- jump_addr_i  in  32  redirect target (word aligned)
- if_addr  out  32  fetch address to memory controller
- if_request  out  1  fetch request, level, registered
- mem_inst_i  in  32  fetched word from memory controller
- mem_inst_valid_i  in  1  one-cycle completion pulse for mem_inst_i
- pc_o  out  32  PC of the word on inst_o
- inst_o  out  32  instruction word to IF/ID
- valid_o  out  1  inst_o/pc_o valid this cycle

## Operation
- States: RUN, MISS, DISCARD.
- RUN: lookup pc; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]. Hit and not stall_i: drive word, pc += 4. Miss: if_addr <= pc, if_request <= 1, go MISS.
- MISS: if_addr and if_request stay constant. On mem_inst_valid_i: write line (valid, tag, data), present word with valid_o, if_request <= 0, pc += 4, go RUN.
- DISCARD: entered when jump_i arrives in MISS; if_addr/if_request held until mem_inst_valid_i; returned word still written to cache (address is genuine) but never presented; then if_request <= 0, go RUN at redirected pc.
- jump_i in RUN: pc <= jump_addr_i, valid_o next cycle 0; any word presented the same cycle is dropped by IF/ID (jump_i also flushes IF/ID).
- jump_i priority: over stall_i and over a simultaneous mem_inst_valid_i (that response treated as discarded, line still filled).
- stall_i: pc, pc_o, inst_o, valid_o hold; an outstanding miss still completes and is captured into an output holding register, presented once stall_i drops.
- Requests never abort mid-fetch; at most one outstanding.
- Arithmetic: pc + 4 wraps modulo 2^32; no alignment check.

## Timing
- Reset values: if_addr 0, if_request 0, pc_o 0, inst_o 0, valid_o 0, pc = RESET_PC, state RUN, all cache valid bits 0.
- Hit: inst_o/valid_o registered, one cycle after pc presented; back-to-back hits give one instruction per cycle.
- Miss: if_request rises cycle N+1 after lookup; controller pulses mem_inst_valid_i ≥4 cycles later (≥5 if busy with load/store); valid_o the cycle after pulse.
- if_request drops on the edge following the pulse, so the controller sees it low in its next free cycle (no duplicate fetch).
- Reset mid-miss: request drops immediately; any later pulse is ignored (state RUN, request low).
- rdy low: no state change, outputs hold; a pulse arriving with rdy low cannot occur (controller also halted).

## Configuration
- ICACHE_EN defined: cache as above.
- ICACHE_EN undefined: no tag/data arrays; every fetch takes the MISS path; behaviour otherwise identical (two-state RUN/MISS plus DISCARD).

## Test plan
- Reset, RESET_PC=0, memory word 0 = 32'h0000_0093: if_request high with if_addr 0; after pulse inst_o=32'h0000_0093, pc_o=0, valid_o=1; next if_addr=4.
- Loop 0x0..0xC executed twice with ICACHE_EN: second pass no if_request, four valid_o cycles back-to-back.
- jump_i to 0x100 two cycles into a miss at 0x8: if_addr stays 0x8 until pulse, word at 0x8 never on inst_o, next request if_addr=0x100.
- stall_i high across miss completion at 0x10: valid_o held, inst_o appears unchanged after stall_i drops, pc_o=0x10, no second request to 0x10.
- Aliasing: fetch 0x0 then 0x100 (IDX_W=6): second misses, replaces line; refetch 0x0 misses again.
- Assert rst during MISS: if_request 0 same cycle, pc_o 0, valid_o 0; subsequent stray pulse produces no valid_o.
